// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the instruction-memory loader.
// slave = loader side, master = stream source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 4
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Length-prefixed little-endian byte-stream loader for the instruction memory;
// holds the core in reset until a full image is written. IMEM_LOADER_CSUM_EN adds a trailing checksum byte.
module imem_loader #(
    parameter int DEPTH_WORDS = 16,
    parameter int ADDR_W      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_hold,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [ADDR_W:0] word_count
);
    localparam logic [7:0] DEPTH_B = 8'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM,
`endif
        S_FIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   n_words_q;
    logic [ADDR_W:0]   wc_q;
    logic [ADDR_W:0]   wc_next;
    logic [23:0]       word_buf_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              rdy;
    logic              xfer;
    logic              hdr_bad;
    logic              last_word;

    assign rdy = (state_q == S_HDR) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CSUM_EN
              || (state_q == S_CSUM)
`endif
              ;
    assign xfer      = bus.byte_valid && rdy;
    assign hdr_bad   = (bus.byte_data == 8'd0) || (bus.byte_data > DEPTH_B);
    assign wc_next   = wc_q + {{ADDR_W{1'b0}}, 1'b1};
    assign last_word = (lane_q == 2'd3) && (wc_next == n_words_q);

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] csum_q;
    logic [7:0] csum_sum;
    assign csum_sum = csum_q + bus.byte_data;
`endif

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        core_hold = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_HDR;
            S_HDR: begin
                busy = 1'b1;
                if (start)     state_d = S_HDR;
                else if (xfer) state_d = hdr_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                busy = 1'b1;
                if (start) state_d = S_HDR;
                else if (xfer && last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_FIN;
`endif
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
                busy = 1'b1;
                if (start)     state_d = S_HDR;
                else if (xfer) state_d = (csum_sum == 8'd0) ? S_FIN : S_ERR;
            end
`endif
            S_FIN: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
                if (start) state_d = S_HDR;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) state_d = S_HDR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q     <= 2'd0;
            addr_q     <= '0;
            n_words_q  <= '0;
            wc_q       <= '0;
            word_buf_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            // The write port is a single-cycle pulse and reads as zero otherwise.
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            if (start && state_q != S_FIN) begin
                // start wins over a same-cycle byte, which is dropped.
                lane_q <= 2'd0;
                addr_q <= '0;
                wc_q   <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                csum_q <= 8'd0;
`endif
            end else if (xfer && state_q == S_HDR) begin
                n_words_q <= (ADDR_W+1)'(bus.byte_data);
                lane_q    <= 2'd0;
                addr_q    <= '0;
            end else if (xfer && state_q == S_DATA) begin
                lane_q <= lane_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                csum_q <= csum_sum;
`endif
                case (lane_q)
                    2'd0: word_buf_q[7:0]   <= bus.byte_data;
                    2'd1: word_buf_q[15:8]  <= bus.byte_data;
                    2'd2: word_buf_q[23:16] <= bus.byte_data;
                    default: begin
                        we_q    <= 1'b1;
                        waddr_q <= addr_q;
                        wdata_q <= {bus.byte_data, word_buf_q};
                        wc_q    <= wc_next;
                        addr_q  <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                endcase
            end
        end
    end

    assign bus.byte_ready = rdy;
    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign word_count     = wc_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default build; checksum scenarios under IMEM_LOADER_CSUM_EN).
module tb_imem_loader;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          core_hold, busy, done, err;
    logic [AW:0]   word_count;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int idle_junk = 0;
    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];

    // Write monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wa_q.push_back(bus.imem_waddr);
            wd_q.push_back(bus.imem_wdata);
        end else if (bus.imem_waddr !== '0 || bus.imem_wdata !== '0) begin
            idle_junk++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waits = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && waits < 20) begin
            tick();
            waits++;
        end
        total++;
        if (waits >= 20) begin
            bad++;
            $display("FAIL send_timeout: byte_ready got %b want 1 for byte %02h", bus.byte_ready, b);
        end
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hFF;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        total++; if (core_hold !== 1'b1) begin bad++; $display("FAIL rst_core_hold: got %b want 1", core_hold); end
        total++; if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL rst_byte_ready: got %b want 0", bus.byte_ready); end
        total++; if (bus.imem_we !== 1'b0) begin bad++; $display("FAIL rst_imem_we: got %b want 0", bus.imem_we); end
        total++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_flags: got done=%b err=%b busy=%b want 0", done, err, busy); end
        total++; if (word_count !== '0) begin bad++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
        rst_n = 1'b1;
        bus.byte_valid = 1'b0;
        tick();
        total++; if (bus.byte_ready !== 1'b0 || core_hold !== 1'b1) begin bad++; $display("FAIL idle_after_rst: got ready=%b hold=%b want 0/1", bus.byte_ready, core_hold); end
    endtask

    // N=2 image, optionally with an idle cycle between every byte.
    task automatic load_n2(input bit gap, input string tag);
        logic [7:0]    img [9] = '{8'h02, 8'h13, 8'h01, 8'h50, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00};
        logic [31:0]   exp_d [2] = '{32'h00500113, 32'h002081B3};
        wa_q.delete(); wd_q.delete();
        pulse_start();
        total++; if (busy !== 1'b1 || bus.byte_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL %s_hdr: got busy=%b ready=%b done=%b want 1/1/0", tag, busy, bus.byte_ready, done); end
        for (int i = 0; i < 9; i++) begin
            send_byte(img[i]);
`ifdef IMEM_LOADER_CSUM_EN
            if (gap) tick();
`else
            if (gap && i < 8) tick();
`endif
        end
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'h48);
`endif
        total++; if (done !== 1'b0 || core_hold !== 1'b1) begin bad++; $display("FAIL %s_fin: got done=%b hold=%b want 0/1", tag, done, core_hold); end
        tick();
        total++; if (done !== 1'b1 || core_hold !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s_done: got done=%b hold=%b busy=%b want 1/0/0", tag, done, core_hold, busy); end
        total++; if (word_count !== 5'd2) begin bad++; $display("FAIL %s_word_count: got %0d want 2", tag, word_count); end
        total++;
        if (wa_q.size() != 2) begin
            bad++; $display("FAIL %s_nwrites: got %0d want 2", tag, wa_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (wa_q[i] !== AW'(i) || wd_q[i] !== exp_d[i]) begin
                    bad++; $display("FAIL %s_write%0d: got addr=%0d data=%08h want addr=%0d data=%08h", tag, i, wa_q[i], wd_q[i], i, exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        load_n2(1'b0, "b2b");
    endtask

    task automatic test_throttled();
        load_n2(1'b1, "throttle");
    endtask

    task automatic test_bad_header();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h00);
        total++; if (err !== 1'b1 || core_hold !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL hdr0_err: got err=%b hold=%b busy=%b want 1/1/0", err, core_hold, busy); end
        total++; if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL hdr0_ready: got %b want 0", bus.byte_ready); end
        bus.byte_valid = 1'b1; bus.byte_data = 8'h01;
        repeat (2) tick();
        bus.byte_valid = 1'b0;
        total++; if (err !== 1'b1 || word_count !== '0) begin bad++; $display("FAIL err_sticky: got err=%b wc=%0d want 1/0", err, word_count); end
        pulse_start();
        total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL err_restart: got err=%b busy=%b want 0/1", err, busy); end
        send_byte(8'h11);
        total++; if (err !== 1'b1 || core_hold !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL hdr17_err: got err=%b hold=%b done=%b want 1/1/0", err, core_hold, done); end
        // N == DEPTH is the largest legal header.
        pulse_start();
        send_byte(8'h10);
        total++; if (err !== 1'b0 || busy !== 1'b1 || bus.byte_ready !== 1'b1) begin bad++; $display("FAIL hdr16_ok: got err=%b busy=%b ready=%b want 0/1/1", err, busy, bus.byte_ready); end
        total++; if (wa_q.size() != 0) begin bad++; $display("FAIL hdr_nowrite: got %0d writes want 0", wa_q.size()); end
    endtask

    task automatic test_abort_start();
        logic [7:0] part [6] = '{8'h13, 8'h01, 8'h50, 8'h00, 8'hB3, 8'h81};
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h02);
        for (int i = 0; i < 6; i++) send_byte(part[i]);
        total++; if (word_count !== 5'd1) begin bad++; $display("FAIL abort_wc1: got %0d want 1", word_count); end
        // start together with a byte: the byte must be dropped.
        bus.byte_valid = 1'b1; bus.byte_data = 8'h00;
        pulse_start();
        bus.byte_valid = 1'b0;
        total++; if (word_count !== '0 || busy !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL abort_clear: got wc=%0d busy=%b err=%b want 0/1/0", word_count, busy, err); end
        send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'hF2);
`endif
        tick();
        total++; if (done !== 1'b1 || word_count !== 5'd1) begin bad++; $display("FAIL abort_reload: got done=%b wc=%0d want 1/1", done, word_count); end
        total++;
        if (wa_q.size() != 2) begin
            bad++; $display("FAIL abort_nwrites: got %0d want 2", wa_q.size());
        end else begin
            total++; if (wa_q[0] !== 4'd0 || wd_q[0] !== 32'h00500113) begin bad++; $display("FAIL abort_w0: got %0d/%08h want 0/00500113", wa_q[0], wd_q[0]); end
            total++; if (wa_q[1] !== 4'd0 || wd_q[1] !== 32'hDDCCBBAA) begin bad++; $display("FAIL abort_w1: got %0d/%08h want 0/ddccbbaa", wa_q[1], wd_q[1]); end
        end
    endtask

    task automatic test_abort_reset();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h13);
        send_byte(8'h01);
        rst_n = 1'b0;
        #1;
        total++; if (core_hold !== 1'b1 || bus.byte_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mrst_ctrl: got hold=%b ready=%b busy=%b want 1/0/0", core_hold, bus.byte_ready, busy); end
        total++; if (done !== 1'b0 || err !== 1'b0 || word_count !== '0 || bus.imem_we !== 1'b0) begin bad++; $display("FAIL mrst_out: got done=%b err=%b wc=%0d we=%b want 0", done, err, word_count, bus.imem_we); end
        bus.byte_valid = 1'b1; bus.byte_data = 8'h50;
        repeat (2) tick();
        rst_n = 1'b1;
        bus.byte_valid = 1'b0;
        repeat (3) tick();
        total++; if (wa_q.size() != 0) begin bad++; $display("FAIL mrst_nowrite: got %0d writes want 0", wa_q.size()); end
        total++; if (core_hold !== 1'b1 || bus.byte_ready !== 1'b0) begin bad++; $display("FAIL mrst_idle: got hold=%b ready=%b want 1/0", core_hold, bus.byte_ready); end
    endtask

`ifdef IMEM_LOADER_CSUM_EN
    task automatic test_csum(input logic [7:0] c, input bit good);
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h13); send_byte(8'h01); send_byte(8'h50); send_byte(8'h00);
        total++; if (bus.byte_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL csum_wait: got ready=%b done=%b want 1/0", bus.byte_ready, done); end
        send_byte(c);
        if (good) begin
            tick();
            total++; if (done !== 1'b1 || core_hold !== 1'b0) begin bad++; $display("FAIL csum_good: got done=%b hold=%b want 1/0", done, core_hold); end
        end else begin
            total++; if (err !== 1'b1 || core_hold !== 1'b1) begin bad++; $display("FAIL csum_bad: got err=%b hold=%b want 1/1", err, core_hold); end
        end
        tick();
        total++;
        if (wa_q.size() != 1 || wa_q[0] !== 4'd0 || wd_q[0] !== 32'h00500113) begin
            bad++; $display("FAIL csum_write: got n=%0d want 1 write of 00500113 at 0", wa_q.size());
        end
    endtask
`endif

    task automatic test_idle_port();
        total++; if (idle_junk != 0) begin bad++; $display("FAIL idle_port: got %0d nonzero idle cycles want 0", idle_junk); end
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        test_reset();
        test_back_to_back();
        test_bad_header();
        test_throttled();
        test_abort_start();
        test_abort_reset();
`ifdef IMEM_LOADER_CSUM_EN
        test_csum(8'h9C, 1'b1);
        test_csum(8'h9D, 1'b0);
`endif
        test_idle_port();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
